uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 74 +++++++
 rtl/uart_rx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// - Memory-map constants for the UART transmit and receive registers.
// - 2-bit state encoding of the receiver FSM.
package uart_rx_pkg;

    // Memory map: the existing transmit register plus the receive data and status words.
    localparam logic [31:0] UART_ADDR      = 32'h1000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h1000_0004;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0008;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO holding received bytes.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, push_data write request and byte
//   pop             retire the head entry (ignored when empty)
//   head            head entry, zero when empty (combinational)
//   empty, full     occupancy status
//   push_drop       a push was refused because the FIFO was full with no pop
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             push_drop
);
    import uart_rx_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    // Push/pop qualification: a pop frees the slot that a push into a full FIFO needs.
    always_comb begin
        w_do_pop  = pop && (r_count != {(AW+1){1'b0}});
        w_do_push = push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);
        push_drop = push && !w_do_push;
        empty     = (r_count == {(AW+1){1'b0}});
        full      = (r_count == (AW+1)'(DEPTH));
        if (empty) begin
            head = {WIDTH{1'b0}};
        end else begin
            head = r_mem[r_rptr];
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a FWFT receive FIFO and sticky error flags.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   uart_rx_in   asynchronous serial line, idle high
//   rx_pop       retire the FIFO head this cycle
//   err_clr      clear frame_err and overrun
//   rx_data      FIFO head byte, 8'h00 when empty
//   rx_valid     FIFO not empty
//   rx_full      FIFO full
//   frame_err    sticky: a stop bit was sampled low
//   overrun      sticky: a byte arrived while the FIFO was full
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_in,
    input  logic       rx_pop,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);
    import uart_rx_pkg::*;

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_brk;
    logic            r_frame_err;
    logic            r_overrun;

    rx_state_t       w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_brk_nxt;
    logic            w_push;
    logic            w_ferr_set;
    logic            w_rxs;
    logic            w_empty;
    logic            w_push_drop;

    assign w_rxs = r_sync2;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_brk   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_brk   <= w_brk_nxt;
        end
    end

    // Next-state logic. The push is issued combinationally so the byte lands in
    // the FIFO on the stop-sample edge itself.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_brk_nxt   = r_brk;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = {CW{1'b0}};
                if (!w_rxs) begin
                    w_state_nxt = RX_START;
                end else begin
                    w_state_nxt = RX_IDLE;
                end
            end
            RX_START: begin
                // Mid-bit check of the start bit filters short glitches.
                if (r_cnt == CW'(HALF_BIT - 1)) begin
                    w_cnt_nxt = {CW{1'b0}};
                    w_idx_nxt = 3'd0;
                    if (w_rxs) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt = RX_DATA;
                    end
                end else begin
                    w_state_nxt = RX_START;
                end
            end
            RX_DATA: begin
                if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    w_cnt_nxt          = {CW{1'b0}};
                    w_shift_nxt[r_idx] = w_rxs;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_state_nxt = RX_DATA;
                end
            end
            RX_STOP: begin
                w_cnt_nxt = {CW{1'b0}};
                if (r_brk) begin
                    // Wait out a held-low line so a break cannot start a new frame.
                    if (w_rxs) begin
                        w_brk_nxt   = 1'b0;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt = RX_STOP;
                    end
                end else if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    if (w_rxs) begin
                        w_push      = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_brk_nxt   = 1'b1;
                        w_state_nxt = RX_STOP;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    w_state_nxt = RX_STOP;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
                w_brk_nxt   = 1'b0;
            end
        endcase
    end

    // Sticky error flags; a new error event wins over err_clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end else begin
                r_frame_err <= r_frame_err;
            end
            if (w_push_drop) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_shift_nxt),
        .pop       (rx_pop),
        .head      (rx_data),
        .empty     (w_empty),
        .full      (rx_full),
        .push_drop (w_push_drop)
    );

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
// A queue models the receive FIFO; sticky flags are modelled as plain bits.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx_in = 1'b1;
    logic       rx_pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    uart_rx #(
        .CLK_FREQ   (1600),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx_in (uart_rx_in),
        .rx_pop     (rx_pop),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_full    (rx_full),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {7'd0, rx_valid}, {7'd0, q.size() != 0});
        check({tag, ".full"},  {7'd0, rx_full},  {7'd0, q.size() == 4});
        check({tag, ".data"},  rx_data, (q.size() != 0) ? q[0] : 8'h00);
        check({tag, ".ferr"},  {7'd0, frame_err}, {7'd0, m_ferr});
        check({tag, ".ovr"},   {7'd0, overrun},   {7'd0, m_ovr});
    endtask

    // Sends one frame starting at a negedge; the stop bit lasts stop_hold cycles (>= 11).
    task automatic send_frame(input logic [7:0] data, input logic stop, input int stop_hold,
                              input logic pop_at_push, input logic chk_lat);
        uart_rx_in = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = data[i];
            repeat (16) @(negedge clk);
        end
        uart_rx_in = stop;
        repeat (10) @(negedge clk);
        // The next posedge is the stop sample, 154 cycles after the start edge.
        if (chk_lat) check("lat.before", {7'd0, rx_valid}, 8'h00);
        if (pop_at_push) begin
            check("pushpop.head", rx_data, (q.size() != 0) ? q[0] : 8'h00);
            rx_pop = 1'b1;
        end
        @(negedge clk);
        rx_pop = 1'b0;
        if (stop) begin
            if (pop_at_push && q.size() != 0) void'(q.pop_front());
            if (q.size() < 4) q.push_back(data);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        if (chk_lat) check("lat.after", {7'd0, rx_valid}, 8'h01);
        repeat (stop_hold - 11) @(negedge clk);
        uart_rx_in = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_byte(input string tag);
        check({tag, ".head"}, rx_data, (q.size() != 0) ? q[0] : 8'h00);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        int         npop;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");
        repeat (4) @(negedge clk);

        // Test 1: single byte with latency check, then pop
        send_frame(8'hA5, 1'b1, 16, 1'b0, 1'b1);
        check("t1.data", rx_data, 8'hA5);
        check_all("t1");
        pop_byte("t1.pop");
        check("t1.empty.valid", {7'd0, rx_valid}, 8'h00);
        check("t1.empty.data", rx_data, 8'h00);
        pop_byte("t1.popempty");
        check_all("t1.popempty");

        // Test 2: start glitch shorter than half a bit
        uart_rx_in = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx_in = 1'b1;
        repeat (30) @(negedge clk);
        check_all("t2");

        // Test 3: framing error with a held break, recovery, err_clr
        send_frame(8'h3C, 1'b0, 40, 1'b0, 1'b0);
        check("t3.ferr", {7'd0, frame_err}, 8'h01);
        check_all("t3.break");
        send_frame(8'h11, 1'b1, 16, 1'b0, 1'b0);
        check("t3.data", rx_data, 8'h11);
        check_all("t3.recv");
        pop_byte("t3.pop");
        clear_errs();
        check("t3.clr", {7'd0, frame_err}, 8'h00);

        // Test 4: overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 16, 1'b0, 1'b0);
            if (i == 4) check("t4.full", {7'd0, rx_full}, 8'h01);
        end
        check("t4.ovr", {7'd0, overrun}, 8'h01);
        check_all("t4");
        for (int i = 1; i <= 4; i++) begin
            check("t4.order", rx_data, 8'(i));
            pop_byte("t4.pop");
        end
        check("t4.drained", {7'd0, rx_valid}, 8'h00);
        clear_errs();
        check_all("t4.clr");

        // Test 5: full FIFO with pop on the push cycle
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 16, 1'b0, 1'b0);
        send_frame(8'h14, 1'b1, 16, 1'b1, 1'b0);
        check("t5.ovr", {7'd0, overrun}, 8'h00);
        check_all("t5");
        for (int i = 1; i <= 4; i++) begin
            check("t5.order", rx_data, 8'h10 + 8'(i));
            pop_byte("t5.pop");
        end
        check_all("t5.drained");

        // Randomised frames and pops against the queue model
        for (int k = 0; k < 10; k++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 4) != 0);
            send_frame(rb, rstop, 16, 1'b0, 1'b0);
            check_all("rnd.rx");
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) pop_byte("rnd.pop");
            check_all("rnd.after");
        end

        // Test 6: reset during data bit 4 of 0x7E, with stale state present
        send_frame(8'h99, 1'b0, 16, 1'b0, 1'b0);
        send_frame(8'h99, 1'b1, 16, 1'b0, 1'b0);
        uart_rx_in = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx_in = (i == 0) ? 1'b0 : 1'b1;
            repeat (16) @(negedge clk);
        end
        uart_rx_in = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_all("t6.reset");
        repeat (40) @(negedge clk);
        check_all("t6.idle");
        send_frame(8'h42, 1'b1, 16, 1'b0, 1'b0);
        check("t6.data", rx_data, 8'h42);
        check_all("t6.recv");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
